// File: rtl/timer_countdown.sv
// Four-digit BCD MM:SS countdown timer fed by keypad digit strobes and a 1 Hz tick.
// Input edges act on the same clock they are sampled; outputs are purely registered.
module timer_countdown (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] d,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] r_state;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic       r_loadn_q, r_startn_q, r_stopn_q, r_pgt_q;

  logic       w_load_ev, w_start_ev, w_stop_ev, w_tick_ev;
  logic       w_d_ok, w_time_zero, w_dec_zero;
  logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;

  assign w_load_ev   = r_loadn_q  & ~loadn;
  assign w_start_ev  = r_startn_q & ~startn;
  assign w_stop_ev   = r_stopn_q  & ~stopn;
  assign w_tick_ev   = ~r_pgt_q   & pgt_1Hz;
  assign w_d_ok      = (d <= 4'd9);
  assign w_time_zero = ({r_mt, r_mo, r_st, r_so} == 16'h0000);

  // Only a borrow reloads sec_tens to 5, so keyed values 6-9 count down as-is.
  always_comb begin
    w_dec_mt = r_mt;
    w_dec_mo = r_mo;
    w_dec_st = r_st;
    w_dec_so = r_so;
    if (r_so != 4'd0) begin
      w_dec_so = r_so - 4'd1;
    end else begin
      w_dec_so = 4'd9;
      if (r_st != 4'd0) begin
        w_dec_st = r_st - 4'd1;
      end else begin
        w_dec_st = 4'd5;
        if (r_mo != 4'd0) begin
          w_dec_mo = r_mo - 4'd1;
        end else begin
          w_dec_mo = 4'd9;
          w_dec_mt = r_mt - 4'd1;
        end
      end
    end
    w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'h0000);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_loadn_q  <= 1'b1;
      r_startn_q <= 1'b1;
      r_stopn_q  <= 1'b1;
      r_pgt_q    <= 1'b0;
    end else begin
      r_loadn_q  <= loadn;
      r_startn_q <= startn;
      r_stopn_q  <= stopn;
      r_pgt_q    <= pgt_1Hz;
    end
  end

  // Event priority on any one edge: stop, then start, then tick, then load.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_state <= ST_IDLE;
      r_mt    <= 4'd0;
      r_mo    <= 4'd0;
      r_st    <= 4'd0;
      r_so    <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_stop_ev) begin
            {r_mt, r_mo, r_st, r_so} <= 16'h0000;
          end else if (w_start_ev) begin
            if (!w_time_zero) r_state <= ST_RUN;
          end else if (w_load_ev && w_d_ok) begin
            {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, d};
          end
        end
        ST_RUN: begin
          if (w_stop_ev) begin
            r_state <= ST_PAUSE;
          end else if (w_tick_ev) begin
            {r_mt, r_mo, r_st, r_so} <= {w_dec_mt, w_dec_mo, w_dec_st, w_dec_so};
            if (w_dec_zero) r_state <= ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (w_stop_ev) begin
            {r_mt, r_mo, r_st, r_so} <= 16'h0000;
            r_state <= ST_IDLE;
          end else if (w_start_ev) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          if (w_stop_ev) begin
            r_state <= ST_IDLE;
          end else if (!w_start_ev && w_load_ev && w_d_ok) begin
            {r_mt, r_mo, r_st, r_so} <= {12'h000, d};
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;
  assign running  = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown: inputs change on the falling clock edge, outputs checked there too.
module tb_timer_countdown;

  logic       clk;
  logic       clearn;
  logic [3:0] d;
  logic       loadn, pgt_1Hz, startn, stopn;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done;

  int checks;
  int failures;

  timer_countdown dut (
    .clk      (clk),
    .clearn   (clearn),
    .d        (d),
    .loadn    (loadn),
    .pgt_1Hz  (pgt_1Hz),
    .startn   (startn),
    .stopn    (stopn),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tm();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic key(input logic [3:0] v);
    @(negedge clk); d = v; loadn = 1'b0;
    @(negedge clk); loadn = 1'b1;
  endtask

  task automatic start_p();
    @(negedge clk); startn = 1'b0;
    @(negedge clk); startn = 1'b1;
  endtask

  task automatic stop_p();
    @(negedge clk); stopn = 1'b0;
    @(negedge clk); stopn = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk); @(negedge clk); pgt_1Hz = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clearn = 1'b0; d = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1; stopn = 1'b1;
    #12;
    chk("reset_time", tm(), 16'h0000);
    chk("reset_run", {15'd0, running}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    @(negedge clk); clearn = 1'b1;

    // keyed load
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("load_1234", tm(), 16'h1234);
    chk("load_run0", {15'd0, running}, 16'd0);
    key(4'd5);
    chk("load_shift", tm(), 16'h2345);
    key(4'hC);
    chk("load_invalid", tm(), 16'h2345);

    // countdown to done
    stop_p();
    chk("idle_clear", tm(), 16'h0000);
    key(4'd0); key(4'd0); key(4'd0); key(4'd2);
    start_p();
    chk("start_run", {15'd0, running}, 16'd1);
    tick();
    chk("cd_0001", tm(), 16'h0001);
    chk("cd_run_still", {15'd0, running}, 16'd1);
    tick();
    chk("cd_0000", tm(), 16'h0000);
    chk("cd_done", {15'd0, done}, 16'd1);
    chk("cd_run0", {15'd0, running}, 16'd0);
    start_p();
    chk("done_start_ign", {15'd0, done}, 16'd1);
    key(4'd3);
    chk("done_load", tm(), 16'h0003);
    chk("done_load_idle", {14'd0, done, running}, 16'd0);

    // borrow chain
    stop_p();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    start_p(); tick();
    chk("borrow_0959", tm(), 16'h0959);
    stop_p(); stop_p();
    chk("pause_clear", tm(), 16'h0000);
    key(4'd7); key(4'd5);
    start_p(); tick();
    chk("sec_tens_75", tm(), 16'h0074);

    // pause / resume / clear
    stop_p(); stop_p();
    key(4'd3); key(4'd0);
    start_p();
    for (int i = 0; i < 3; i++) tick();
    chk("run_0027", tm(), 16'h0027);
    stop_p();
    chk("paused_run0", {15'd0, running}, 16'd0);
    tick(); tick();
    chk("paused_hold", tm(), 16'h0027);
    start_p();
    chk("resume_run", {15'd0, running}, 16'd1);
    tick();
    chk("resume_0026", tm(), 16'h0026);
    stop_p(); stop_p();
    chk("stop2_time", tm(), 16'h0000);
    chk("stop2_idle", {14'd0, done, running}, 16'd0);

    // stop and tick on the same edge
    key(4'd5);
    start_p();
    @(negedge clk); stopn = 1'b0; pgt_1Hz = 1'b1;
    @(negedge clk); stopn = 1'b1; pgt_1Hz = 1'b0;
    @(negedge clk);
    chk("stop_tick_time", tm(), 16'h0005);
    chk("stop_tick_pause", {15'd0, running}, 16'd0);
    stop_p();

    // start and load on the same edge
    key(4'd4); key(4'd2);
    @(negedge clk); startn = 1'b0; loadn = 1'b0; d = 4'd7;
    @(negedge clk); startn = 1'b1; loadn = 1'b1;
    chk("start_load_time", tm(), 16'h0042);
    chk("start_load_run", {15'd0, running}, 16'd1);
    stop_p(); stop_p();

    // start at zero
    start_p();
    chk("start_zero_idle", {15'd0, running}, 16'd0);

    // asynchronous reset mid-count
    key(4'd5); key(4'd1); key(4'd0);
    start_p();
    chk("pre_reset_run", {15'd0, running}, 16'd1);
    @(negedge clk); #2 clearn = 1'b0;
    #1;
    chk("async_rst_time", tm(), 16'h0000);
    chk("async_rst_run", {15'd0, running}, 16'd0);
    @(negedge clk); clearn = 1'b1;
    tick();
    chk("post_rst_tick", tm(), 16'h0000);
    chk("post_rst_idle", {14'd0, done, running}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
